// File: rtl/gpu_primloader.sv
// Polygon command parser: consumes GP0 0x20-0x3F words, builds up to four vertices and emits
// normalised triangles (quads split into two) over a valid/ready handshake.
module gpu_primloader #(
  parameter int unsigned COORD_W     = 12,
  parameter int unsigned OFFSET_W    = 11,
  parameter int unsigned ENABLE_QUAD = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [31:0]           i_data,
  output logic                  o_ready,
  input  logic [OFFSET_W-1:0]   i_offsetX,
  input  logic [OFFSET_W-1:0]   i_offsetY,
  output logic                  o_triValid,
  input  logic                  i_triReady,
  output logic [3*COORD_W-1:0]  o_triX,
  output logic [3*COORD_W-1:0]  o_triY,
  output logic [26:0]           o_triR,
  output logic [26:0]           o_triG,
  output logic [26:0]           o_triB,
  output logic [23:0]           o_triU,
  output logic [23:0]           o_triV,
  output logic [3:0]            o_triAttr,
  output logic                  o_triLast,
  output logic                  o_badCmd,
  output logic                  o_busy
);

  typedef enum logic [2:0] {StIdle, StLdCol, StLdVtx, StLdUv, StEmit0, StEmit1} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cmd_q;
  logic [1:0]           vtx_q;
  logic [OFFSET_W-1:0]  offx_q, offy_q;
  logic                 bad_q, bad_d;
  logic [COORD_W-1:0]   x_q [4];
  logic [COORD_W-1:0]   y_q [4];
  logic [8:0]           r_q [4];
  logic [8:0]           g_q [4];
  logic [8:0]           b_q [4];
  logic [7:0]           u_q [4];
  logic [7:0]           v_q [4];

  logic                 bad_hdr, hdr_ok, vtx_done, last_vtx;
  logic [7:0]           cmd_cur;
  logic [8:0]           r_new, g_new, b_new;
  logic [COORD_W-1:0]   cx, cy;

  function automatic logic [8:0] conv(input logic [7:0] c, input logic raw, input logic tex);
    if (raw) return 9'd256;
    else if (tex) return {c, 1'b0};
    else return {1'b0, c} + 9'(c[7]);
  endfunction

  assign bad_hdr  = (i_data[31:29] != 3'b001) || (i_data[27] && (ENABLE_QUAD == 0));
  assign hdr_ok   = (state_q == StIdle) && i_valid && !bad_hdr;
  assign last_vtx = (vtx_q == (cmd_q[3] ? 2'd3 : 2'd2));
  // Header colour must be converted with the incoming command, not the stale latched one.
  assign cmd_cur  = (state_q == StIdle) ? i_data[31:24] : cmd_q;
  assign r_new    = conv(i_data[7:0],   cmd_cur[0] & cmd_cur[2], cmd_cur[2]);
  assign g_new    = conv(i_data[15:8],  cmd_cur[0] & cmd_cur[2], cmd_cur[2]);
  assign b_new    = conv(i_data[23:16], cmd_cur[0] & cmd_cur[2], cmd_cur[2]);
  assign cx = {{(COORD_W-11){i_data[10]}}, i_data[10:0]}
            + {{(COORD_W-OFFSET_W){offx_q[OFFSET_W-1]}}, offx_q};
  assign cy = {{(COORD_W-11){i_data[26]}}, i_data[26:16]}
            + {{(COORD_W-OFFSET_W){offy_q[OFFSET_W-1]}}, offy_q};

  always_comb begin
    state_d  = state_q;
    bad_d    = 1'b0;
    vtx_done = 1'b0;
    unique case (state_q)
      StIdle:  if (i_valid) begin
                 if (bad_hdr) bad_d = 1'b1;
                 else         state_d = StLdVtx;
               end
      StLdCol: if (i_valid) state_d = StLdVtx;
      StLdVtx: if (i_valid) begin
                 if (cmd_q[2]) state_d = StLdUv;
                 else          vtx_done = 1'b1;
               end
      StLdUv:  if (i_valid) vtx_done = 1'b1;
      StEmit0: if (i_triReady) state_d = cmd_q[3] ? StEmit1 : StIdle;
      StEmit1: if (i_triReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (vtx_done) state_d = last_vtx ? StEmit0 : (cmd_q[4] ? StLdCol : StLdVtx);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_q  <= '0;
      vtx_q  <= '0;
      offx_q <= '0;
      offy_q <= '0;
      bad_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        x_q[k] <= '0; y_q[k] <= '0;
        r_q[k] <= '0; g_q[k] <= '0; b_q[k] <= '0;
        u_q[k] <= '0; v_q[k] <= '0;
      end
    end else begin
      bad_q <= bad_d;
      if (hdr_ok) begin
        cmd_q  <= i_data[31:24];
        vtx_q  <= 2'd0;
        offx_q <= i_offsetX;
        offy_q <= i_offsetY;
        // Broadcast colour0; gouraud primitives overwrite vertices 1..N-1 later.
        for (int k = 0; k < 4; k++) begin
          r_q[k] <= r_new; g_q[k] <= g_new; b_q[k] <= b_new;
        end
      end
      if (state_q == StLdCol && i_valid) begin
        r_q[vtx_q] <= r_new; g_q[vtx_q] <= g_new; b_q[vtx_q] <= b_new;
      end
      if (state_q == StLdVtx && i_valid) begin
        x_q[vtx_q] <= cx;
        y_q[vtx_q] <= cy;
      end
      if (state_q == StLdUv && i_valid) begin
        u_q[vtx_q] <= i_data[7:0];
        v_q[vtx_q] <= i_data[15:8];
      end
      if (vtx_done && !last_vtx) vtx_q <= vtx_q + 2'd1;
    end
  end

  logic [1:0] base, idx;

  always_comb begin
    o_ready    = (state_q != StEmit0) && (state_q != StEmit1);
    o_busy     = (state_q != StIdle);
    o_badCmd   = bad_q;
    o_triValid = 1'b0;
    o_triLast  = 1'b0;
    o_triAttr  = '0;
    o_triX     = '0;
    o_triY     = '0;
    o_triR     = '0;
    o_triG     = '0;
    o_triB     = '0;
    o_triU     = '0;
    o_triV     = '0;
    base       = (state_q == StEmit1) ? 2'd1 : 2'd0;
    idx        = '0;
    if (!o_ready) begin
      o_triValid = 1'b1;
      o_triLast  = (state_q == StEmit1) || !cmd_q[3];
      o_triAttr  = {cmd_q[1], cmd_q[2], cmd_q[4], cmd_q[0] & cmd_q[2]};
      for (int k = 0; k < 3; k++) begin
        idx = base + 2'(k);
        o_triX[k*COORD_W +: COORD_W] = x_q[idx];
        o_triY[k*COORD_W +: COORD_W] = y_q[idx];
        o_triR[k*9 +: 9] = r_q[idx];
        o_triG[k*9 +: 9] = g_q[idx];
        o_triB[k*9 +: 9] = b_q[idx];
        o_triU[k*8 +: 8] = u_q[idx];
        o_triV[k*8 +: 8] = v_q[idx];
      end
    end
  end

endmodule
